// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-8 handshake demultiplexer.
// Lane count, select/count widths, lane select type and a popcount helper.
package demux_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;
    localparam int CNT_W     = 4;

    typedef logic [SEL_W-1:0] lane_sel_t;

    function automatic logic [CNT_W-1:0] popcount(
        input logic [NUM_LANES-1:0] v
    );
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/demux_1to8_nw_if.sv
// Handshake bundle between producer, demux and the eight lane consumers.
// master: producer/consumer side; slave: demux side.
// With DEMUX_BROADCAST_EN defined the bundle also carries InBcast.
interface demux_1to8_nw_if
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0]     InData;
    lane_sel_t            InSel;
    logic                 InValid;
    logic                 InReady;
`ifdef DEMUX_BROADCAST_EN
    logic                 InBcast;
`endif
    logic [WIDTH-1:0]     OutData [NUM_LANES];
    logic [NUM_LANES-1:0] OutValid;
    logic [NUM_LANES-1:0] OutReady;
    logic [CNT_W-1:0]     LaneCnt;

    modport master (
        output InData,
        output InSel,
        output InValid,
        input  InReady,
`ifdef DEMUX_BROADCAST_EN
        output InBcast,
`endif
        input  OutData,
        input  OutValid,
        output OutReady,
        input  LaneCnt
    );

    modport slave (
        input  InData,
        input  InSel,
        input  InValid,
        output InReady,
`ifdef DEMUX_BROADCAST_EN
        input  InBcast,
`endif
        output OutData,
        output OutValid,
        input  OutReady,
        output LaneCnt
    );

endinterface

// File: rtl/demux_lane_reg.sv
// One-entry lane buffer: holds a word until its consumer takes it.
// Ports: Clk, ResetN, Load/LoadData in, OutReady in, OutData/OutValid/CanLoad out.
module demux_lane_reg #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadData,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData,
    output logic             OutValid,
    output logic             CanLoad
);

    // Draining on the same edge frees the slot, so a full lane
    // can still take a new word when its consumer is ready.
    assign CanLoad = !OutValid || OutReady;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            OutData  <= '0;
            OutValid <= 1'b0;
        end else if (Load) begin
            OutData  <= LoadData;
            OutValid <= 1'b1;
        end else if (OutReady) begin
            OutValid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1to8_nw.sv
// 1-to-8 demux with valid/ready on input and per-lane outputs.
// Ports: Clk, ResetN, bus (slave: InData/InSel/InValid/InReady,
// OutData/OutValid/OutReady, LaneCnt). DEMUX_BROADCAST_EN adds InBcast.
module demux_1to8_nw
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            Clk,
    input  logic            ResetN,
    demux_1to8_nw_if.slave  bus
);

    logic [NUM_LANES-1:0] sel_hot;
    logic [NUM_LANES-1:0] can_load;
    logic [NUM_LANES-1:0] load;
    logic [NUM_LANES-1:0] valid;
    logic [NUM_LANES-1:0] nxt_valid;
    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic [WIDTH-1:0]     lane_data [NUM_LANES];

    assign sel_hot = NUM_LANES'(1) << bus.InSel;

`ifdef DEMUX_BROADCAST_EN
    // Broadcast waits until every lane can take the word.
    assign bus.InReady = bus.InBcast ? (&can_load)
                                     : can_load[bus.InSel];
    assign accept = bus.InValid && bus.InReady;
    assign load   = !accept   ? '0 :
                    bus.InBcast ? '1 : sel_hot;
`else
    assign bus.InReady = can_load[bus.InSel];
    assign accept = bus.InValid && bus.InReady;
    assign load   = accept ? sel_hot : '0;
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        demux_lane_reg #(
            .WIDTH(WIDTH)
        ) u_lane (
            .Clk      (Clk),
            .ResetN   (ResetN),
            .Load     (load[i]),
            .LoadData (bus.InData),
            .OutReady (bus.OutReady[i]),
            .OutData  (lane_data[i]),
            .OutValid (valid[i]),
            .CanLoad  (can_load[i])
        );
        assign bus.OutData[i] = lane_data[i];
    end

    // Counting the next-state valids keeps LaneCnt aligned
    // with OutValid in the same cycle.
    assign nxt_valid = load | (valid & ~bus.OutReady);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            cnt <= '0;
        end else begin
            cnt <= popcount(nxt_valid);
        end
    end

    assign bus.OutValid = valid;
    assign bus.LaneCnt  = cnt;

endmodule

// File: tb/tb_demux_1to8_nw.sv
// Directed table-driven bench for demux_1to8_nw (WIDTH=8).
// Broadcast sequence runs only when DEMUX_BROADCAST_EN is defined.
module tb_demux_1to8_nw;
    import demux_pkg::*;

    typedef struct {
        logic [7:0] rdy;
        logic       vld;
        logic [2:0] sel;
        logic [7:0] data;
        logic       bcast;
        logic       exp_ready;
        logic [7:0] exp_valid;
        logic [3:0] exp_cnt;
        logic [2:0] chk_lane;
        logic [7:0] exp_data;
    } vec_t;

    logic Clk;
    logic ResetN;
    int   passed;
    int   total;
    vec_t tbl [64];
    int   n_vec;

    demux_1to8_nw_if #(.WIDTH(8)) bus ();

    demux_1to8_nw #(
        .WIDTH(8)
    ) dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(
        input logic [7:0] rdy,
        input logic       vld,
        input logic [2:0] sel,
        input logic [7:0] data,
        input logic       bcast,
        input logic       exp_ready,
        input logic [7:0] exp_valid,
        input logic [3:0] exp_cnt,
        input logic [2:0] chk_lane,
        input logic [7:0] exp_data
    );
        tbl[n_vec] = '{rdy, vld, sel, data, bcast, exp_ready,
                       exp_valid, exp_cnt, chk_lane, exp_data};
        n_vec++;
    endtask

    // Called one time unit after a rising edge.
    task automatic step(input vec_t v, input int idx);
        bus.OutReady = v.rdy;
        bus.InValid  = v.vld;
        bus.InSel    = v.sel;
        bus.InData   = v.data;
`ifdef DEMUX_BROADCAST_EN
        bus.InBcast  = v.bcast;
`endif
        #1;
        check($sformatf("v%0d ready", idx), 32'(bus.InReady),
              32'(v.exp_ready));
        @(posedge Clk);
        #1;
        check($sformatf("v%0d valid", idx), 32'(bus.OutValid),
              32'(v.exp_valid));
        check($sformatf("v%0d cnt", idx), 32'(bus.LaneCnt),
              32'(v.exp_cnt));
        check($sformatf("v%0d data", idx),
              32'(bus.OutData[v.chk_lane]), 32'(v.exp_data));
    endtask

    initial begin
        vec_t v;
        logic [7:0] m;
        passed = 0;
        total  = 0;
        n_vec  = 0;

        // unicast sweep, consumers always ready
        for (int i = 0; i < 8; i++) begin
            add(8'hFF, 1, 3'(i), 8'hA0 + 8'(i), 0, 1,
                8'h01 << i, 4'd1, 3'(i), 8'hA0 + 8'(i));
        end
        add(8'hFF, 0, 3'd7, 8'h00, 0, 1, 8'h00, 4'd0, 3'd7, 8'hA7);
        // backpressure on lane 2
        add(8'h00, 1, 3'd2, 8'h11, 0, 1, 8'h04, 4'd1, 3'd2, 8'h11);
        add(8'h00, 1, 3'd2, 8'h22, 0, 0, 8'h04, 4'd1, 3'd2, 8'h11);
        add(8'h04, 1, 3'd2, 8'h22, 0, 1, 8'h04, 4'd1, 3'd2, 8'h22);
        // independent lane while lane 2 stalls
        add(8'h00, 1, 3'd5, 8'h33, 0, 1, 8'h24, 4'd2, 3'd5, 8'h33);
        add(8'hFF, 0, 3'd0, 8'h00, 0, 1, 8'h00, 4'd0, 3'd2, 8'h22);
        // fill all lanes
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m = m | (8'h01 << i);
            add(8'h00, 1, 3'(i), 8'h40 + 8'(i), 0, 1,
                m, 4'(i + 1), 3'(i), 8'h40 + 8'(i));
        end
        for (int i = 0; i < 8; i++) begin
            add(8'h00, 1, 3'(i), 8'h99, 0, 0,
                8'hFF, 4'd8, 3'(i), 8'h40 + 8'(i));
        end
        // partial drain, select is don't-care with InValid low
        add(8'h0F, 0, 3'd6, 8'h77, 0, 0, 8'hF0, 4'd4, 3'd6, 8'h46);
        add(8'hFF, 0, 3'd0, 8'h00, 0, 1, 8'h00, 4'd0, 3'd0, 8'h40);
        // lanes 0,3,7 full ahead of the mid-traffic reset
        add(8'h00, 1, 3'd0, 8'hC0, 0, 1, 8'h01, 4'd1, 3'd0, 8'hC0);
        add(8'h00, 1, 3'd3, 8'hC3, 0, 1, 8'h09, 4'd2, 3'd3, 8'hC3);
        add(8'h00, 1, 3'd7, 8'hC7, 0, 1, 8'h89, 4'd3, 3'd7, 8'hC7);

        bus.OutReady = 8'h00;
        bus.InValid  = 1'b0;
        bus.InSel    = 3'd0;
        bus.InData   = 8'h00;
`ifdef DEMUX_BROADCAST_EN
        bus.InBcast  = 1'b0;
`endif
        ResetN = 1'b0;
        #2;
        check("rst valid", 32'(bus.OutValid), 32'h0);
        check("rst cnt", 32'(bus.LaneCnt), 32'h0);
        check("rst data3", 32'(bus.OutData[3]), 32'h0);
        @(posedge Clk);
        #1;
        ResetN = 1'b1;
        #1;
        check("rst ready", 32'(bus.InReady), 32'h1);
        @(posedge Clk);
        #1;

        for (int i = 0; i < n_vec; i++) begin
            v = tbl[i];
            step(v, i);
        end

        // mid-traffic async reset, 3 ns low between edges
        ResetN = 1'b0;
        #1;
        check("mid valid", 32'(bus.OutValid), 32'h0);
        check("mid cnt", 32'(bus.LaneCnt), 32'h0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("mid data%0d", i),
                  32'(bus.OutData[i]), 32'h0);
        end
        #2;
        ResetN = 1'b1;
        bus.OutReady = 8'h00;
        bus.InValid  = 1'b0;
        #1;
        check("mid ready", 32'(bus.InReady), 32'h1);
        @(posedge Clk);
        #1;
        check("post valid", 32'(bus.OutValid), 32'h0);

`ifdef DEMUX_BROADCAST_EN
        v = '{8'h00, 1, 3'd4, 8'h44, 0, 1, 8'h10, 4'd1, 3'd4, 8'h44};
        step(v, 100);
        v = '{8'h00, 1, 3'd1, 8'h5A, 1, 0, 8'h10, 4'd1, 3'd4, 8'h44};
        step(v, 101);
        v = '{8'h10, 1, 3'd1, 8'h5A, 1, 1, 8'hFF, 4'd8, 3'd4, 8'h5A};
        step(v, 102);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bc data%0d", i),
                  32'(bus.OutData[i]), 32'h5A);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
